// File: rtl/vgpr_busy_scoreboard_pkg.sv
// Shared constants, window-size encoding and helpers for the VGPR busy scoreboard.
package vgpr_busy_scoreboard_pkg;

    localparam int NUMBER_VGPR      = 1024;
    localparam int VGPR_ADDR_LENGTH = 10;

    localparam int NUM_REGS  = NUMBER_VGPR;
    localparam int ADDR_W    = VGPR_ADDR_LENGTH;
    localparam int MAX_WORDS = 4;
    localparam int NUM_QRY   = 3;
    localparam int NUM_WB    = 2;
    localparam int SIZE_W    = 3;

    // Window-size encoding: value is the register count, 0 and > MAX_WORDS are illegal.
    typedef enum logic [SIZE_W-1:0] {
        SzNone = 3'd0,
        SzOne  = 3'd1,
        SzTwo  = 3'd2,
        SzThr  = 3'd3,
        SzFour = 3'd4
    } win_size_e;

    function automatic logic size_valid(input logic [SIZE_W-1:0] size);
        return (size != 3'd0) && (int'(size) <= MAX_WORDS);
    endfunction

    // Rotate-by-base read: table extended by MAX_WORDS low bits, shifted right by base.
    function automatic logic [MAX_WORDS-1:0] rot_window(input logic [NUM_REGS-1:0] tab,
                                                        input logic [ADDR_W-1:0]   base);
        logic [NUM_REGS+MAX_WORDS-1:0] ext;
        ext = {tab[MAX_WORDS-1:0], tab} >> base;
        return ext[MAX_WORDS-1:0];
    endfunction

endpackage

// File: rtl/vgpr_busy_scoreboard_if.sv
// Issue-stage bus of the VGPR busy scoreboard: set, clear, flush and query ports.
interface vgpr_busy_scoreboard_if;
    import vgpr_busy_scoreboard_pkg::*;

    logic                        set_en;
    logic [ADDR_W-1:0]           set_addr;
    logic [SIZE_W-1:0]           set_size;
    logic [NUM_WB-1:0]           clr_en;
    logic [NUM_WB*ADDR_W-1:0]    clr_addr;
    logic [NUM_WB*SIZE_W-1:0]    clr_size;
    logic                        flush;
    logic [NUM_QRY-1:0]          qry_en;
    logic [NUM_QRY*ADDR_W-1:0]   qry_addr;
    logic [NUM_QRY*MAX_WORDS-1:0] qry_busy;
    logic [NUM_QRY-1:0]          qry_valid;
    logic                        err_dbl_set;

    modport master (
        output set_en, set_addr, set_size, clr_en, clr_addr, clr_size, flush,
               qry_en, qry_addr,
        input  qry_busy, qry_valid, err_dbl_set
    );

    modport slave (
        input  set_en, set_addr, set_size, clr_en, clr_addr, clr_size, flush,
               qry_en, qry_addr,
        output qry_busy, qry_valid, err_dbl_set
    );

endinterface

// File: rtl/vgpr_window_decode.sv
// Base/size to NUM_REGS-bit window mask; addresses wrap at the top of the file.
module vgpr_window_decode
    import vgpr_busy_scoreboard_pkg::*;
(
    input  logic [ADDR_W-1:0]   i_base,
    input  logic [SIZE_W-1:0]   i_size,
    output logic [NUM_REGS-1:0] o_mask
);

    // Illegal sizes produce an empty mask, which drops the operation.
    always_comb begin
        o_mask = '0;
        if (size_valid(i_size)) begin
            for (int k = 0; k < MAX_WORDS; k++) begin
                if (k < int'(i_size)) begin
                    o_mask[i_base + ADDR_W'(k)] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/vgpr_busy_scoreboard.sv
// VGPR busy scoreboard: issue sets windows busy, writeback clears them,
// queries return the registered next-state window of MAX_WORDS registers.
module vgpr_busy_scoreboard
    import vgpr_busy_scoreboard_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    vgpr_busy_scoreboard_if.slave  bus
);

    logic [NUM_REGS-1:0]  r_tab;
    logic [NUM_REGS-1:0]  w_tab_d;
    logic [NUM_REGS-1:0]  w_set_mask;
    logic [NUM_REGS-1:0]  w_set_hit;
    logic [NUM_REGS-1:0]  w_clr_mask [NUM_WB];
    logic [NUM_REGS-1:0]  w_clr_any;
    logic                 w_dbl_set;

    logic [NUM_QRY*MAX_WORDS-1:0] r_qry_busy;
    logic [NUM_QRY*MAX_WORDS-1:0] w_qry_win;
    logic [NUM_QRY-1:0]           r_qry_valid;
    logic                         r_err;

    vgpr_window_decode u_set_dec (
        .i_base (bus.set_addr),
        .i_size (bus.set_size),
        .o_mask (w_set_mask)
    );

    for (genvar g = 0; g < NUM_WB; g++) begin : g_clr
        vgpr_window_decode u_clr_dec (
            .i_base (bus.clr_addr[g*ADDR_W +: ADDR_W]),
            .i_size (bus.clr_size[g*SIZE_W +: SIZE_W]),
            .o_mask (w_clr_mask[g])
        );
    end

    // Next-state table: flush beats everything, set beats same-cycle clear.
    always_comb begin
        w_set_hit = w_set_mask & {NUM_REGS{bus.set_en}};
        w_clr_any = '0;
        for (int g = 0; g < NUM_WB; g++) begin
            w_clr_any = w_clr_any | (w_clr_mask[g] & {NUM_REGS{bus.clr_en[g]}});
        end
        w_dbl_set = |(w_set_hit & r_tab & ~w_clr_any);
        w_tab_d   = bus.flush ? '0 : (w_set_hit | (r_tab & ~w_clr_any));
    end

    // Queries read the next-state table so back-to-back issue sees this cycle's updates.
    for (genvar p = 0; p < NUM_QRY; p++) begin : g_qry
        assign w_qry_win[p*MAX_WORDS +: MAX_WORDS] =
            rot_window(w_tab_d, bus.qry_addr[p*ADDR_W +: ADDR_W]);
    end

    // Busy table and sticky double-set error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tab <= '0;
            r_err <= 1'b0;
        end else begin
            r_tab <= w_tab_d;
            if (w_dbl_set) begin
                r_err <= 1'b1;
            end
        end
    end

    // Query result registers; an idle port holds its last window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_qry_busy  <= '0;
            r_qry_valid <= '0;
        end else begin
            r_qry_valid <= bus.qry_en;
            for (int p = 0; p < NUM_QRY; p++) begin
                if (bus.qry_en[p]) begin
                    r_qry_busy[p*MAX_WORDS +: MAX_WORDS] <= w_qry_win[p*MAX_WORDS +: MAX_WORDS];
                end
            end
        end
    end

    assign bus.qry_busy    = r_qry_busy;
    assign bus.qry_valid   = r_qry_valid;
    assign bus.err_dbl_set = r_err;

endmodule

// File: tb/tb_vgpr_busy_scoreboard.sv
// Randomized + directed bench for vgpr_busy_scoreboard against an array-based model.
module tb_vgpr_busy_scoreboard;
    import vgpr_busy_scoreboard_pkg::*;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    vgpr_busy_scoreboard_if u_if ();

    vgpr_busy_scoreboard u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one bit per register, window membership by modular distance.
    bit             m_tab   [NUM_REGS];
    logic [3:0]     m_busy  [NUM_QRY];
    bit             m_valid [NUM_QRY];
    bit             m_err;

    function automatic bit in_win(int r, int base, int size);
        if (size < 1 || size > MAX_WORDS) return 1'b0;
        return ((r - base + NUM_REGS) % NUM_REGS) < size;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NUM_REGS; r++) m_tab[r] = 1'b0;
        for (int p = 0; p < NUM_QRY; p++) begin
            m_busy[p]  = 4'b0;
            m_valid[p] = 1'b0;
        end
        m_err = 1'b0;
    endtask

    task automatic model_step();
        bit nxt [NUM_REGS];
        bit s;
        bit c;
        int qa;
        for (int r = 0; r < NUM_REGS; r++) begin
            s = u_if.set_en && in_win(r, int'(u_if.set_addr), int'(u_if.set_size));
            c = 1'b0;
            for (int w = 0; w < NUM_WB; w++) begin
                if (u_if.clr_en[w] && in_win(r, int'(u_if.clr_addr[w*ADDR_W +: ADDR_W]),
                                             int'(u_if.clr_size[w*SIZE_W +: SIZE_W])))
                    c = 1'b1;
            end
            if (s && m_tab[r] && !c) m_err = 1'b1;
            nxt[r] = u_if.flush ? 1'b0 : (s || (m_tab[r] && !c));
        end
        for (int r = 0; r < NUM_REGS; r++) m_tab[r] = nxt[r];
        for (int p = 0; p < NUM_QRY; p++) begin
            m_valid[p] = u_if.qry_en[p];
            if (u_if.qry_en[p]) begin
                qa = int'(u_if.qry_addr[p*ADDR_W +: ADDR_W]);
                for (int k = 0; k < MAX_WORDS; k++) m_busy[p][k] = m_tab[(qa + k) % NUM_REGS];
            end
        end
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int p = 0; p < NUM_QRY; p++) begin
            chk($sformatf("valid%0d", p), 32'(u_if.qry_valid[p]), 32'(m_valid[p]));
            chk($sformatf("busy%0d", p), 32'(u_if.qry_busy[p*MAX_WORDS +: MAX_WORDS]),
                32'(m_busy[p]));
        end
        chk("err", 32'(u_if.err_dbl_set), 32'(m_err));
    endtask

    task automatic idle();
        u_if.set_en   = 1'b0;
        u_if.set_addr = '0;
        u_if.set_size = '0;
        u_if.clr_en   = '0;
        u_if.clr_addr = '0;
        u_if.clr_size = '0;
        u_if.flush    = 1'b0;
        u_if.qry_en   = '0;
        u_if.qry_addr = '0;
    endtask

    task automatic do_set(int a, int s);
        u_if.set_en   = 1'b1;
        u_if.set_addr = ADDR_W'(a);
        u_if.set_size = SIZE_W'(s);
    endtask

    task automatic do_clr(int w, int a, int s);
        u_if.clr_en[w] = 1'b1;
        u_if.clr_addr[w*ADDR_W +: ADDR_W] = ADDR_W'(a);
        u_if.clr_size[w*SIZE_W +: SIZE_W] = SIZE_W'(s);
    endtask

    task automatic do_qry(int p, int a);
        u_if.qry_en[p] = 1'b1;
        u_if.qry_addr[p*ADDR_W +: ADDR_W] = ADDR_W'(a);
    endtask

    // One clock: model samples the same inputs as the DUT, compare 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        idle();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(u_if.qry_busy), 32'd0);
        chk("rst_valid", 32'(u_if.qry_valid), 32'd0);
        chk("rst_err", 32'(u_if.err_dbl_set), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic rand_phase(int n);
        int a;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                a = $urandom_range(0, 11);
                do_set(a < 6 ? a : NUM_REGS - 12 + a, $urandom_range(0, 5));
            end
            for (int w = 0; w < NUM_WB; w++) begin
                if ($urandom_range(0, 1) == 1) begin
                    a = $urandom_range(0, 11);
                    do_clr(w, a < 6 ? a : NUM_REGS - 12 + a, $urandom_range(0, 5));
                end
            end
            u_if.flush = ($urandom_range(0, 39) == 0);
            for (int p = 0; p < NUM_QRY; p++) begin
                if ($urandom_range(0, 3) != 0) begin
                    a = $urandom_range(0, 11);
                    do_qry(p, a < 6 ? a : NUM_REGS - 12 + a);
                end
            end
            cycle();
        end
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        model_reset();
        #12;
        apply_reset();

        // 1: query after reset
        do_qry(0, 0);
        cycle();
        chk("t1_busy", 32'(u_if.qry_busy[3:0]), 32'h0);
        chk("t1_valid", 32'(u_if.qry_valid[0]), 32'h1);

        // 2: set visible in same-cycle query
        do_set(2, 4);
        do_qry(0, 0);
        cycle();
        chk("t2_q0", 32'(u_if.qry_busy[3:0]), 32'hC);
        do_qry(1, 4);
        cycle();
        chk("t2_q4", 32'(u_if.qry_busy[7:4]), 32'h3);
        chk("t2_hold", 32'(u_if.qry_busy[3:0]), 32'hC);

        // 3: wrap past the top
        u_if.flush = 1'b1;
        cycle();
        do_set(1022, 4);
        do_qry(0, 1022);
        cycle();
        chk("t3_q1022", 32'(u_if.qry_busy[3:0]), 32'hF);
        do_qry(2, 0);
        cycle();
        chk("t3_q0", 32'(u_if.qry_busy[11:8]), 32'h3);

        // 4: set wins over clear; double-set sticky
        do_set(5, 1);
        cycle();
        do_set(5, 1);
        do_clr(0, 5, 1);
        do_qry(0, 5);
        cycle();
        chk("t4_busy", 32'(u_if.qry_busy[0]), 32'h1);
        chk("t4_err0", 32'(u_if.err_dbl_set), 32'h0);
        do_set(5, 1);
        cycle();
        chk("t4_err1", 32'(u_if.err_dbl_set), 32'h1);
        cycle();
        chk("t4_sticky", 32'(u_if.err_dbl_set), 32'h1);

        // 5: two clear ports, illegal sizes dropped
        do_set(8, 4);
        cycle();
        do_clr(0, 8, 2);
        do_clr(1, 10, 2);
        do_qry(0, 8);
        cycle();
        chk("t5_clr", 32'(u_if.qry_busy[3:0]), 32'h0);
        do_set(8, 0);
        do_qry(1, 8);
        cycle();
        chk("t5_sz0", 32'(u_if.qry_busy[7:4]), 32'h0);
        do_set(8, 5);
        do_qry(1, 8);
        cycle();
        chk("t5_sz5", 32'(u_if.qry_busy[7:4]), 32'h0);

        // 6: async reset mid-sequence, then flush vs set
        do_set(20, 4);
        do_qry(0, 20);
        cycle();
        do_qry(0, 20);
        do_qry(1, 20);
        @(negedge clk);
        apply_reset();
        do_set(30, 4);
        cycle();
        do_set(40, 2);
        u_if.flush = 1'b1;
        do_qry(0, 40);
        do_qry(1, 30);
        cycle();
        chk("t6_flush40", 32'(u_if.qry_busy[3:0]), 32'h0);
        chk("t6_flush30", 32'(u_if.qry_busy[7:4]), 32'h0);

        // Random traffic around both ends of the register file
        rand_phase(400);
        @(negedge clk);
        apply_reset();
        rand_phase(400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
